hls_macc_seq: RTL and testbench
===============================

// Module: hls_macc_seq
// PURPOSE
// Parametrised successor of the fixed 10-input MAC kernel: a time-multiplexed signed dot-product
// engine, result = sat((bias + [acc_prev] + sum a[i]*b[i]) >>> shift, rounded), one multiplier.
// Sits behind an ap_ctrl_hs controller like other kernels; adds accumulate mode, rounding, saturation.
// PARAMETERS
// W        32   operand/result width (bits, signed)
// N_TERMS  4    number of a*b products per transaction (>=1)
// ACC_W    72   internal accumulator width; must be >= 2*W+clog2(N_TERMS)+1
// SAT      1    1: saturate result to W bits; 0: wrap (truncate)
// PORTS
// ap_clk          in   1          clock, all logic rising-edge
// ap_rst_n        in   1          asynchronous active-low reset
// ap_start        in   1          start request (ap_ctrl_hs)
// ap_done         out  1          one-cycle pulse, result valid
// ap_idle         out  1          high in IDLE with ap_start low
// ap_ready        out  1          inputs consumed; equals ap_done
// in_a            in   N_TERMS*W  operand vector a, term i at [i*W +: W]
// in_b            in   N_TERMS*W  operand vector b, same packing
// in_bias         in   W          signed bias, sign-extended to ACC_W
// in_shift        in   6          arithmetic right shift, 0..2*W-1
// mode_acc        in   1          1: add persistent accumulator to this sum
// out_acc         out  W          final result
// out_acc_ap_vld  out  1          equals ap_done
// out_ovf         out  1          saturation/wrap occurred; valid with ap_done
// ap_return       out  W          equals out_acc
// BEHAVIOUR
// - Reset (async, ap_rst_n=0): state IDLE; ap_done/ap_ready/out_acc_ap_vld=0, ap_idle=1 once ap_start
//   low; out_acc/ap_return/out_ovf=0; persistent accumulator acc_state=0; index counter=0.
// - FSM one-hot: IDLE -> MAC -> POST -> DONE -> IDLE.
//   IDLE: if ap_start=1, latch in_a,in_b,in_bias,in_shift,mode_acc into regs; sum <= sext(bias) +
//   (mode_acc ? acc_state : 0); idx<=0; go MAC. Inputs after this edge are ignored.
//   MAC: cycle k registers prod=a[k]*b[k] (signed, 2W) and adds prior prod to sum; takes N_TERMS+1
//   cycles (1-stage product pipe, last cycle drains); go POST.
//   POST: full-width sum -> acc_state (ACC_W, no saturation); result computed by round/shift/sat.
//   DONE: ap_done=ap_ready=out_acc_ap_vld=1 for exactly this cycle; go IDLE unconditionally.
// - Latency: ap_done high N_TERMS+3 cycles after the accepting edge (N_TERMS=4 -> 7).
// - Back-to-back: ap_start held high re-accepts in the IDLE cycle after DONE (throughput N_TERMS+4).
// - ap_start in MAC/POST/DONE is ignored; no queuing.
// - Rounding: shift>0 -> add 1<<(shift-1) before >>> (round half up, toward +inf); shift=0 exact.
// - Saturation (SAT=1): clamp to [-2^(W-1), 2^(W-1)-1], out_ovf=1 if clamped. SAT=0: low W bits,
//   out_ovf=1 if discarded bits are not sign extension. in_shift >= 2*W treated as 2*W-1.
// - out_acc/out_ovf registered in POST, hold value until next POST or reset.
// - acc_state wraps modulo 2^ACC_W; only written in POST; reset mid-transaction aborts, no output.
// STRUCTURE
// - Package hls_macc_pkg: state one-hot localparams (S_IDLE..S_DONE), clog2 function,
//   signed-saturate function, ACC_W legality check constant.
// - Sub-module hls_macc_post: combinational round/shift/saturate, (sum, shift) -> (result, ovf).
// - Top: FSM, input capture regs, idx counter, multiplier + product reg, accumulator, acc_state.
// TESTING (W=32, N_TERMS=4, SAT=1 unless stated)
// - a={1,2,3,4}, b={5,6,7,8}, bias=0, shift=0, mode_acc=0 -> out_acc=70, ovf=0, done at cycle 7.
// - a={-3,2,-1,4}, b={5,-6,7,8}, bias=-10 -> -15-12-7+32-10 = -12 (0xFFFFFFF4).
// - Rounding: sum 13, shift 2 -> 3; sum 14, shift 2 -> 4; sum -14, shift 2 -> -3.
// - Saturation: a=b all 0x7FFFFFFF -> out_acc=0x7FFFFFFF, ovf=1; SAT=0 build -> wrap, ovf=1.
// - Accumulate: vector 1 mode_acc=0 -> 70, repeat mode_acc=1 -> 140; ap_start held -> 2nd done at 7+8.
// - Reset asserted during MAC cycle 2 -> all outputs 0 immediately, acc_state=0, no ap_done;
//   next transaction with mode_acc=1 returns plain 70.

Source files
------------

// File: rtl/hls_macc_pkg.sv
// rtl/hls_macc_pkg.sv - shared constants and helpers for the hls_macc_seq dot-product engine
//
// Purpose: one-hot FSM state encodings, a constant clog2, the accumulator
// width legality check and the signed saturation (range) check used by the
// post-processing stage.
// Ports: none (package).
package hls_macc_pkg;

  localparam logic [3:0] S_IDLE = 4'b0001;
  localparam logic [3:0] S_MAC  = 4'b0010;
  localparam logic [3:0] S_POST = 4'b0100;
  localparam logic [3:0] S_DONE = 4'b1000;

  // Widest value the saturation check can inspect.
  localparam int MAX_ACC_W = 128;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Accumulator must hold N_TERMS full products plus bias without overflow,
  // and one guard bit for rounding must still fit the saturation checker.
  function automatic bit acc_w_ok(input int acc_w, input int w, input int n_terms);
    return (acc_w >= 2 * w + clog2(n_terms) + 1) && (acc_w < MAX_ACC_W);
  endfunction

  // Returns 1 when v lies outside the signed w-bit range, i.e. saturation
  // (or, in wrap mode, loss of information) occurs.
  function automatic logic sat_signed_ovf(input logic signed [MAX_ACC_W-1:0] v, input int w);
    logic signed [MAX_ACC_W-1:0] lo;
    logic signed [MAX_ACC_W-1:0] hi;
    lo = '1;
    lo = lo <<< (w - 1);
    hi = ~lo;
    return (v > hi) || (v < lo);
  endfunction

endpackage

// File: rtl/hls_macc_post.sv
// rtl/hls_macc_post.sv - combinational round, arithmetic shift and saturate stage
//
// Purpose: (sum, shift) -> (result, ovf). Rounds half up (toward +inf) by
// adding 1<<(shift-1) before the arithmetic shift; shift values beyond
// 2*W-1 are clamped. With SAT=1 the result is clamped to the signed W-bit
// range, otherwise the low W bits are returned. ovf flags either case.
// Ports:
//   sum    in   ACC_W  signed full-width accumulator value
//   shift  in   6      right shift amount
//   result out  W      rounded/shifted/saturated value
//   ovf    out  1      value did not fit in W signed bits
module hls_macc_post
  import hls_macc_pkg::*;
#(
  parameter int W     = 32,
  parameter int ACC_W = 72,
  parameter bit SAT   = 1'b1
) (
  input  logic signed [ACC_W-1:0] sum,
  input  logic        [5:0]       shift,
  output logic        [W-1:0]     result,
  output logic                    ovf
);

  // One extra bit so that adding the rounding constant cannot wrap.
  localparam int EW = ACC_W + 1;

  int                     sh_eff;
  logic signed [EW-1:0]   ext;
  logic signed [EW-1:0]   rnd;
  logic signed [EW-1:0]   shifted;

  always_comb begin
    sh_eff = (int'(shift) > 2 * W - 1) ? 2 * W - 1 : int'(shift);
    ext    = EW'(sum);
    rnd    = '0;
    if (sh_eff > 0) rnd[sh_eff-1] = 1'b1;
    shifted = (ext + rnd) >>> sh_eff;
    ovf     = sat_signed_ovf(MAX_ACC_W'(shifted), W);
    if (SAT && ovf) begin
      result = shifted[EW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      result = shifted[W-1:0];
    end
  end

endmodule

// File: rtl/hls_macc_seq.sv
// rtl/hls_macc_seq.sv - time-multiplexed signed dot-product engine with ap_ctrl_hs handshake
//
// Purpose: result = sat((bias + [acc_state] + sum a[i]*b[i]) >>> shift, rounded)
// using a single multiplier, one product per cycle.
// Ports:
//   ap_clk, ap_rst_n          clock, asynchronous active-low reset
//   ap_start/done/idle/ready  ap_ctrl_hs block handshake
//   in_a, in_b                N_TERMS*W operand vectors, term i at [i*W +: W]
//   in_bias                   signed bias
//   in_shift                  arithmetic right shift amount
//   mode_acc                  add persistent accumulator into this sum
//   out_acc, ap_return        result (registered, held until next result)
//   out_acc_ap_vld            result valid strobe (= ap_done)
//   out_ovf                   result was saturated / wrapped
module hls_macc_seq
  import hls_macc_pkg::*;
#(
  parameter int W       = 32,
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 72,
  parameter bit SAT     = 1'b1
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic                 ap_start,
  output logic                 ap_done,
  output logic                 ap_idle,
  output logic                 ap_ready,
  input  logic [N_TERMS*W-1:0] in_a,
  input  logic [N_TERMS*W-1:0] in_b,
  input  logic [W-1:0]         in_bias,
  input  logic [5:0]           in_shift,
  input  logic                 mode_acc,
  output logic [W-1:0]         out_acc,
  output logic                 out_acc_ap_vld,
  output logic                 out_ovf,
  output logic [W-1:0]         ap_return
);

  localparam int PW    = 2 * W;
  localparam int IDX_W = clog2(N_TERMS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_TERMS);

  if (!acc_w_ok(ACC_W, W, N_TERMS)) begin : g_bad_acc_w
    $error("hls_macc_seq: ACC_W too small for W and N_TERMS");
  end

  logic [3:0]              state_q, state_d;
  logic [N_TERMS*W-1:0]    a_q, b_q;
  logic [5:0]              shift_q;
  logic [IDX_W-1:0]        idx_q;
  logic signed [PW-1:0]    prod_q;
  logic signed [ACC_W-1:0] sum_q;
  logic signed [ACC_W-1:0] acc_state;
  logic [W-1:0]            out_acc_q;
  logic                    ovf_q;

  logic signed [W-1:0]     a_sel, b_sel;
  logic signed [PW-1:0]    prod_w;
  logic                    mac_last;
  logic [W-1:0]            post_res;
  logic                    post_ovf;

  // idx walks 0..N_TERMS; the final value is the drain cycle that only adds
  // the last registered product.
  assign mac_last = (idx_q == LAST_IDX);

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < N_TERMS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_sel = a_q[i*W +: W];
        b_sel = b_q[i*W +: W];
      end
    end
  end

  assign prod_w = PW'(a_sel) * PW'(b_sel);

  // State register
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (ap_start) state_d = S_MAC;
      S_MAC:   if (mac_last) state_d = S_POST;
      S_POST:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    ap_done        = (state_q == S_DONE);
    ap_ready       = (state_q == S_DONE);
    out_acc_ap_vld = (state_q == S_DONE);
    ap_idle        = (state_q == S_IDLE) && !ap_start;
  end

  // Datapath
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      shift_q   <= '0;
      idx_q     <= '0;
      prod_q    <= '0;
      sum_q     <= '0;
      acc_state <= '0;
      out_acc_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ap_start) begin
            a_q     <= in_a;
            b_q     <= in_b;
            shift_q <= in_shift;
            idx_q   <= '0;
            prod_q  <= '0;
            sum_q   <= ACC_W'(signed'(in_bias)) + (mode_acc ? acc_state : '0);
          end
        end
        S_MAC: begin
          sum_q  <= sum_q + ACC_W'(prod_q);
          prod_q <= mac_last ? '0 : prod_w;
          idx_q  <= idx_q + 1'b1;
        end
        S_POST: begin
          acc_state <= sum_q;
          out_acc_q <= post_res;
          ovf_q     <= post_ovf;
        end
        default: ;
      endcase
    end
  end

  hls_macc_post #(
    .W     (W),
    .ACC_W (ACC_W),
    .SAT   (SAT)
  ) u_post (
    .sum    (sum_q),
    .shift  (shift_q),
    .result (post_res),
    .ovf    (post_ovf)
  );

  assign out_acc   = out_acc_q;
  assign ap_return = out_acc_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_hls_macc_seq.sv
// tb/tb_hls_macc_seq.sv - directed self-checking bench for hls_macc_seq (SAT=1 and SAT=0 builds)
module tb_hls_macc_seq;

  localparam int W = 32;
  localparam int N = 4;

  logic           ap_clk = 1'b0;
  logic           ap_rst_n = 1'b0;
  logic           ap_start = 1'b0;
  logic [N*W-1:0] in_a = '0;
  logic [N*W-1:0] in_b = '0;
  logic [W-1:0]   in_bias = '0;
  logic [5:0]     in_shift = '0;
  logic           mode_acc = 1'b0;

  logic           ap_done, ap_idle, ap_ready, out_acc_ap_vld, out_ovf;
  logic [W-1:0]   out_acc, ap_return;
  logic           w_done, w_idle, w_ready, w_vld, w_ovf;
  logic [W-1:0]   w_acc, w_ret;

  int tests = 0;
  int fails = 0;

  always #5 ap_clk = ~ap_clk;

  hls_macc_seq #(.W(W), .N_TERMS(N), .ACC_W(72), .SAT(1'b1)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_done(ap_done),
    .ap_idle(ap_idle), .ap_ready(ap_ready), .in_a(in_a), .in_b(in_b), .in_bias(in_bias),
    .in_shift(in_shift), .mode_acc(mode_acc), .out_acc(out_acc),
    .out_acc_ap_vld(out_acc_ap_vld), .out_ovf(out_ovf), .ap_return(ap_return)
  );

  hls_macc_seq #(.W(W), .N_TERMS(N), .ACC_W(72), .SAT(1'b0)) dut_wrap (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_done(w_done),
    .ap_idle(w_idle), .ap_ready(w_ready), .in_a(in_a), .in_b(in_b), .in_bias(in_bias),
    .in_shift(in_shift), .mode_acc(mode_acc), .out_acc(w_acc),
    .out_acc_ap_vld(w_vld), .out_ovf(w_ovf), .ap_return(w_ret)
  );

  function automatic logic [N*W-1:0] pack(input int x0, input int x1, input int x2, input int x3);
    return {x3, x2, x1, x0};
  endfunction

  // Applies one transaction in the current IDLE cycle (cycle 0) and returns
  // the cycle number in which ap_done is seen, or -1 on timeout.
  task automatic run_txn(input logic [N*W-1:0] a, input logic [N*W-1:0] b,
                         input logic [W-1:0] bias, input logic [5:0] sh,
                         input logic m, output int lat);
    @(negedge ap_clk);
    in_a = a; in_b = b; in_bias = bias; in_shift = sh; mode_acc = m; ap_start = 1'b1;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge ap_clk);
      #1 ap_start = 1'b0;
      @(negedge ap_clk);
      if (ap_done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge ap_clk);
    tests++; if (ap_idle !== 1'b1) begin fails++; $display("FAIL reset_idle got=%b exp=1", ap_idle); end
    tests++; if ({ap_done, ap_ready, out_acc_ap_vld} !== 3'b000) begin fails++; $display("FAIL reset_done got=%b exp=000", {ap_done, ap_ready, out_acc_ap_vld}); end
    tests++; if ({out_acc, ap_return, out_ovf} !== '0) begin fails++; $display("FAIL reset_out got=%h/%h/%b exp=0", out_acc, ap_return, out_ovf); end
    ap_rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat;
    run_txn(pack(1, 2, 3, 4), pack(5, 6, 7, 8), 32'd0, 6'd0, 1'b0, lat);
    tests++; if (lat !== 7) begin fails++; $display("FAIL basic_latency got=%0d exp=7", lat); end
    tests++; if (out_acc !== 32'd70) begin fails++; $display("FAIL basic_out got=%0d exp=70", out_acc); end
    tests++; if (ap_return !== 32'd70) begin fails++; $display("FAIL basic_return got=%0d exp=70", ap_return); end
    tests++; if ({ap_ready, out_acc_ap_vld, out_ovf} !== 3'b110) begin fails++; $display("FAIL basic_flags got=%b exp=110", {ap_ready, out_acc_ap_vld, out_ovf}); end
    tests++; if (w_acc !== 32'd70) begin fails++; $display("FAIL basic_wrap_out got=%0d exp=70", w_acc); end
    @(negedge ap_clk);
    tests++; if (ap_done !== 1'b0) begin fails++; $display("FAIL basic_done_pulse got=%b exp=0", ap_done); end
    tests++; if (out_acc !== 32'd70) begin fails++; $display("FAIL basic_hold got=%0d exp=70", out_acc); end
    tests++; if (ap_idle !== 1'b1) begin fails++; $display("FAIL basic_idle_after got=%b exp=1", ap_idle); end
  endtask

  task automatic test_signed();
    int lat;
    run_txn(pack(-3, 2, -1, 4), pack(5, -6, 7, 8), -32'sd10, 6'd0, 1'b0, lat);
    tests++; if (out_acc !== 32'hFFFF_FFF4 || out_ovf !== 1'b0) begin fails++; $display("FAIL signed_out got=%h ovf=%b exp=fffffff4 ovf=0", out_acc, out_ovf); end
  endtask

  task automatic test_rounding();
    int lat;
    logic [W-1:0] bias_t [6] = '{32'd13, 32'd14, -32'sd14, -32'sd3, 32'd70, -32'sd1};
    logic [5:0]   sh_t   [6] = '{6'd2, 6'd2, 6'd2, 6'd1, 6'd0, 6'd63};
    logic [W-1:0] exp_t  [6] = '{32'd3, 32'd4, -32'sd3, -32'sd1, 32'd70, 32'd0};
    for (int i = 0; i < 6; i++) begin
      run_txn('0, '0, bias_t[i], sh_t[i], 1'b0, lat);
      tests++; if (out_acc !== exp_t[i] || out_ovf !== 1'b0) begin fails++; $display("FAIL round_%0d got=%h ovf=%b exp=%h ovf=0", i, out_acc, out_ovf, exp_t[i]); end
    end
  endtask

  task automatic test_saturation();
    int lat;
    logic [N*W-1:0] pmax, nmin;
    pmax = {N{32'h7FFF_FFFF}};
    nmin = {N{32'h8000_0000}};
    run_txn(pmax, pmax, 32'd0, 6'd0, 1'b0, lat);
    tests++; if (out_acc !== 32'h7FFF_FFFF || out_ovf !== 1'b1) begin fails++; $display("FAIL sat_pos got=%h ovf=%b exp=7fffffff ovf=1", out_acc, out_ovf); end
    tests++; if (w_acc !== 32'h0000_0004 || w_ovf !== 1'b1) begin fails++; $display("FAIL wrap_pos got=%h ovf=%b exp=00000004 ovf=1", w_acc, w_ovf); end
    run_txn(nmin, pmax, 32'd0, 6'd0, 1'b0, lat);
    tests++; if (out_acc !== 32'h8000_0000 || out_ovf !== 1'b1) begin fails++; $display("FAIL sat_neg got=%h ovf=%b exp=80000000 ovf=1", out_acc, out_ovf); end
    tests++; if (w_acc !== 32'h0000_0000 || w_ovf !== 1'b1) begin fails++; $display("FAIL wrap_neg got=%h ovf=%b exp=00000000 ovf=1", w_acc, w_ovf); end
    run_txn(pmax, pmax, 32'd0, 6'd33, 1'b0, lat);
    tests++; if (out_acc !== 32'h7FFF_FFFE || out_ovf !== 1'b0) begin fails++; $display("FAIL sat_shift got=%h ovf=%b exp=7ffffffe ovf=0", out_acc, out_ovf); end
  endtask

  task automatic test_back_to_back();
    int d1, d2, extra;
    logic [W-1:0] r1, r2;
    d1 = -1; d2 = -1; r1 = '0; r2 = '0; extra = 0;
    @(negedge ap_clk);
    in_a = pack(1, 2, 3, 4); in_b = pack(5, 6, 7, 8); in_bias = '0; in_shift = '0;
    mode_acc = 1'b0; ap_start = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(posedge ap_clk);
      @(negedge ap_clk);
      if (c == 1) mode_acc = 1'b1;
      if (ap_done) begin
        if (d1 < 0) begin d1 = c; r1 = out_acc; end
        else begin d2 = c; r2 = out_acc; ap_start = 1'b0; break; end
      end
    end
    ap_start = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge ap_clk);
      if (ap_done) extra++;
    end
    tests++; if (d1 !== 7 || r1 !== 32'd70) begin fails++; $display("FAIL b2b_first got=cycle %0d val %0d exp=cycle 7 val 70", d1, r1); end
    tests++; if (d2 !== 15 || r2 !== 32'd140) begin fails++; $display("FAIL b2b_second got=cycle %0d val %0d exp=cycle 15 val 140", d2, r2); end
    tests++; if (extra !== 0) begin fails++; $display("FAIL b2b_no_extra got=%0d exp=0", extra); end
  endtask

  task automatic test_reset_mid();
    int lat, seen;
    seen = 0;
    @(negedge ap_clk);
    in_a = pack(1, 2, 3, 4); in_b = pack(5, 6, 7, 8); in_bias = '0; in_shift = '0;
    mode_acc = 1'b1; ap_start = 1'b1;
    @(posedge ap_clk);
    #1 ap_start = 1'b0;
    @(posedge ap_clk);
    #2 ap_rst_n = 1'b0;
    #1;
    tests++; if ({out_acc, ap_return, out_ovf, ap_done} !== '0) begin fails++; $display("FAIL midreset_out got=%h/%h/%b/%b exp=0", out_acc, ap_return, out_ovf, ap_done); end
    tests++; if (ap_idle !== 1'b1 || w_acc !== '0) begin fails++; $display("FAIL midreset_idle got=%b/%h exp=1/0", ap_idle, w_acc); end
    for (int c = 0; c < 4; c++) begin
      @(negedge ap_clk);
      if (ap_done) seen++;
    end
    ap_rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge ap_clk);
      if (ap_done) seen++;
    end
    tests++; if (seen !== 0) begin fails++; $display("FAIL midreset_no_done got=%0d exp=0", seen); end
    run_txn(pack(1, 2, 3, 4), pack(5, 6, 7, 8), 32'd0, 6'd0, 1'b1, lat);
    tests++; if (lat !== 7 || out_acc !== 32'd70) begin fails++; $display("FAIL midreset_acc_cleared got=cycle %0d val %0d exp=cycle 7 val 70", lat, out_acc); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_rounding();
    test_saturation();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
